// File: rtl/ram_tick_arbiter.sv
// Tick-paced arbiter sharing one single-port RAM between a writer and a reader.
// Optional overrun counter enabled by defining RAM_ARB_OVF_CNT_EN.
module ram_tick_arbiter #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              sysClk,
    input  logic              sysRst_n,
    input  logic              initTick,
    input  logic              readTick,
    input  logic              wrReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrGnt,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdGnt,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramDin,
    output logic              ramCe,
    output logic              ramWe,
    input  logic [DATA_W-1:0] ramDout,
    output logic              busy,
    output logic [7:0]        ovfCnt
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdWait} state_e;

    // Remaining RD_WAIT cycles after the first one; unused when RD_LAT is 1.
    localparam logic [2:0] WaitInit = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_e            state_q, state_d;
    logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic              last_rd_q, last_rd_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d, rd_data_q, rd_data_d;
    logic              ram_ce_d, ram_we_d, wr_gnt_d, rd_gnt_d, rd_valid_d;
    logic              ram_ce_q, ram_we_q, wr_gnt_q, rd_gnt_q, rd_valid_q;
    logic              wr_elig, rd_elig;

    assign wr_elig = wrReq && wr_pend_q;
    assign rd_elig = rdReq && rd_pend_q;

    always_comb begin
        state_d    = state_q;
        last_rd_d  = last_rd_q;
        wait_cnt_d = wait_cnt_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rd_data_d  = rd_data_q;
        ram_ce_d   = 1'b0;
        ram_we_d   = 1'b0;
        wr_gnt_d   = 1'b0;
        rd_gnt_d   = 1'b0;
        rd_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_elig && (!rd_elig || last_rd_q)) begin
                    state_d    = StWrite;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    wr_gnt_d   = 1'b1;
                    ram_addr_d = wrAddr;
                    ram_din_d  = wrData;
                    last_rd_d  = 1'b0;
                end else if (rd_elig) begin
                    state_d    = StRead;
                    ram_ce_d   = 1'b1;
                    rd_gnt_d   = 1'b1;
                    ram_addr_d = rdAddr;
                    last_rd_d  = 1'b1;
                end
            end
            StWrite: state_d = StIdle;
            StRead: begin
                if (RD_LAT == 1) begin
                    state_d    = StIdle;
                    rd_data_d  = ramDout;
                    rd_valid_d = 1'b1;
                end else begin
                    state_d    = StRdWait;
                    wait_cnt_d = WaitInit;
                end
            end
            StRdWait: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d    = StIdle;
                    rd_data_d  = ramDout;
                    rd_valid_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A tick landing in the grant cycle re-arms the slot instead of being lost.
    always_comb begin
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        if (initTick) wr_pend_d = 1'b1;
        else if (wr_gnt_q) wr_pend_d = 1'b0;
        if (readTick) rd_pend_d = 1'b1;
        else if (rd_gnt_q) rd_pend_d = 1'b0;
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_q    <= StIdle;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            last_rd_q  <= 1'b1;
            wait_cnt_q <= 3'd0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rd_data_q  <= '0;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            last_rd_q  <= last_rd_d;
            wait_cnt_q <= wait_cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rd_data_q  <= rd_data_d;
            ram_ce_q   <= ram_ce_d;
            ram_we_q   <= ram_we_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef RAM_ARB_OVF_CNT_EN
    logic [7:0] ovf_q, ovf_d;
    logic [8:0] ovf_sum;
    logic       wr_drop, rd_drop;

    always_comb begin
        wr_drop = initTick && wr_pend_q && !wr_gnt_q;
        rd_drop = readTick && rd_pend_q && !rd_gnt_q;
        ovf_sum = {1'b0, ovf_q} + 9'(wr_drop) + 9'(rd_drop);
        ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) ovf_q <= 8'd0;
        else ovf_q <= ovf_d;
    end

    assign ovfCnt = ovf_q;
`else
    assign ovfCnt = 8'd0;
`endif

    assign ramAddr = ram_addr_q;
    assign ramDin  = ram_din_q;
    assign ramCe   = ram_ce_q;
    assign ramWe   = ram_we_q;
    assign wrGnt   = wr_gnt_q;
    assign rdGnt   = rd_gnt_q;
    assign rdValid = rd_valid_q;
    assign rdData  = rd_data_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: doc/ram_tick_arbiter.md
RAM_TICK_ARBITER -- requirements
Module: ram_tick_arbiter

Interface
REQ-001 Parameter ADDR_W, default 18: RAM address width.
REQ-002 Parameter DATA_W, default 16: RAM data width.
REQ-003 Parameter RD_LAT, default 2, legal range 1..7: cycles from the registered RAM address to valid ramDout.
REQ-004 sysClk  in  1  sole clock; all state changes on its rising edge.
REQ-005 sysRst_n  in  1  asynchronous, active-low reset.
REQ-006 initTick  in  1  one-cycle write-slot strobe from the clock divider.
REQ-007 readTick  in  1  one-cycle read-slot strobe from the clock divider.
REQ-008 wrReq  in  1; wrAddr  in  ADDR_W; wrData  in  DATA_W: write request, held by the requester until wrGnt.
REQ-009 wrGnt  out  1  one-cycle pulse; write performed this cycle.
REQ-010 rdReq  in  1; rdAddr  in  ADDR_W: read request, held by the requester until rdGnt.
REQ-011 rdGnt  out  1  one-cycle pulse; read address issued this cycle.
REQ-012 rdValid  out  1  one-cycle pulse; rdData valid.
REQ-013 rdData  out  DATA_W  captured read data, held until the next capture.
REQ-014 ramAddr  out  ADDR_W; ramDin  out  DATA_W; ramCe  out  1; ramWe  out  1: single-port RAM drive, all registered.
REQ-015 ramDout  in  DATA_W  RAM read data.
REQ-016 busy  out  1  high whenever the FSM is not IDLE.
REQ-017 ovfCnt  out  8  tick-overrun counter (see Configuration).

Function
REQ-018 Pending flags wrPend and rdPend SHALL set on initTick and readTick respectively, and clear on the corresponding grant.
REQ-019 A tick arriving while its pend flag is already set SHALL be dropped and counted as an overrun.
REQ-020 A tick coinciding with a grant of the same type SHALL leave the pend flag set.
REQ-021 Eligibility: write when wrReq && wrPend; read when rdReq && rdPend.
REQ-022 FSM states: IDLE, WRITE, READ, RD_WAIT; the decision is made in IDLE only.
REQ-023 IDLE at cycle t, write eligible and granted: WRITE at t+1 with ramCe=1, ramWe=1, ramAddr=wrAddr, ramDin=wrData, wrGnt=1; IDLE at t+2.
REQ-024 IDLE at cycle t, read granted: READ at t+1 with ramCe=1, ramWe=0, ramAddr=rdAddr, rdGnt=1.
REQ-025 After READ, RD_WAIT SHALL last RD_LAT-1 cycles.
REQ-026 ramDout SHALL be captured into rdData at cycle t+1+RD_LAT, with rdValid=1 in that same cycle.
REQ-027 After the capture cycle the FSM SHALL return to IDLE.
REQ-028 With RD_LAT=1, RD_WAIT SHALL be skipped.
REQ-029 When both are eligible in the same IDLE cycle, the type not granted last SHALL win; the lastWasRead flag updates on every grant.
REQ-030 Requests and ticks that arrive while busy SHALL only be latched; there is no preemption.
REQ-031 Outside WRITE and READ: ramCe=0 and ramWe=0; ramAddr and ramDin hold their last value.
REQ-032 Back-to-back grants SHALL be separated by at least one IDLE cycle.

Reset
REQ-033 sysRst_n low SHALL immediately force: state=IDLE, wrPend=0, rdPend=0, lastWasRead=1 (write wins the first tie), ramCe=0, ramWe=0, wrGnt=0, rdGnt=0, rdValid=0, busy=0, ramAddr=0, ramDin=0, rdData=0, ovfCnt=0.
REQ-034 A read in flight at reset SHALL be abandoned; no rdValid is produced after release.
REQ-035 The first grant SHALL be evaluated no earlier than the first rising edge after deassertion.

Configuration
REQ-036 Macro RAM_ARB_OVF_CNT_EN defined: ovfCnt SHALL increment by 1 per dropped tick, saturate at 255, and count 2 when both tick types overrun in the same cycle.
REQ-037 Macro RAM_ARB_OVF_CNT_EN undefined: ovfCnt SHALL be constant 0, no counter logic is built, and all other behaviour is identical.

Verification
REQ-038 Reset release, then initTick at t with wrReq=1, wrAddr=0x00010, wrData=0xBEEF -> at t+2: ramWe=1, ramCe=1, ramAddr=0x00010, ramDin=0xBEEF, wrGnt=1; busy low at t+3.
REQ-039 RD_LAT=2, readTick with rdReq=1, rdAddr=0x00010, model returns 0xBEEF -> rdGnt one cycle, then rdValid exactly 2 cycles later with rdData=0xBEEF.
REQ-040 Both pend flags set and both requests held in the same IDLE cycle after reset -> write granted first, then read; repeated ties alternate.
REQ-041 readTick asserted 3 times during a long read with RD_LAT=7 -> exactly one further read granted; ovfCnt=2 with the macro defined, 0 without.
REQ-042 sysRst_n pulsed low during RD_WAIT -> all outputs 0 asynchronously, no rdValid afterwards, and the next readTick is serviced normally.
